// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler
// Shares one combinational ALU among NUM_REQ requesters. A round-robin
// arbiter picks one valid requester while idle. Its opcode and operands are
// registered onto the ALU inputs. One cycle later the ALU result and flags are
// captured into a response register, which is held until the sink accepts it.
//
// state     | meaning
// ----------+----------------------------------------------------------------
// ST_IDLE   | waiting for a request; grants and registers operands same cycle
// ST_EXEC   | ALU inputs stable; result/flags captured at the end of the cycle
// ST_RESP   | response valid; held until rsp_ready, then back to idle

module alu_rr_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   parameter int OP_W    = 4,
   parameter int ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*OP_W-1:0]   req_opcode,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   output logic [OP_W-1:0]           alu_opcode,
   output logic [DATA_W-1:0]         alu_a,
   output logic [DATA_W-1:0]         alu_b,
   input  logic [DATA_W-1:0]         alu_out,
   input  logic                      alu_negative,
   input  logic                      alu_overflow,
   input  logic                      alu_zero,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         rsp_out,
   output logic                      rsp_negative,
   output logic                      rsp_overflow,
   output logic                      rsp_zero,
   output logic [15:0]               ops_done
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]         state_q,        state_d;
   logic [ID_W-1:0]    rr_ptr_q,       rr_ptr_d;
   logic [ID_W-1:0]    id_q,           id_d;
   logic [OP_W-1:0]    alu_opcode_q,   alu_opcode_d;
   logic [DATA_W-1:0]  alu_a_q,        alu_a_d;
   logic [DATA_W-1:0]  alu_b_q,        alu_b_d;
   logic               rsp_valid_q,    rsp_valid_d;
   logic [ID_W-1:0]    rsp_id_q,       rsp_id_d;
   logic [DATA_W-1:0]  rsp_out_q,      rsp_out_d;
   logic               rsp_negative_q, rsp_negative_d;
   logic               rsp_overflow_q, rsp_overflow_d;
   logic               rsp_zero_q,     rsp_zero_d;
   logic [15:0]        ops_done_q,     ops_done_d;

   logic [OP_W-1:0]    op_arr [NUM_REQ];
   logic [DATA_W-1:0]  a_arr  [NUM_REQ];
   logic [DATA_W-1:0]  b_arr  [NUM_REQ];

   logic               grant_found;
   logic [ID_W-1:0]    grant_idx;
   logic [ID_W:0]      cand;
   logic [NUM_REQ-1:0] ready_c;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign op_arr[i] = req_opcode[i*OP_W +: OP_W];
      assign a_arr[i]  = req_a[i*DATA_W +: DATA_W];
      assign b_arr[i]  = req_b[i*DATA_W +: DATA_W];
   end

   // Round-robin search: first valid index starting at rr_ptr, wrapping at NUM_REQ.
   // The candidate carries one extra bit so the wrap works for non-power-of-2 counts.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(NUM_REQ)) begin
            cand = cand - (ID_W+1)'(NUM_REQ);
         end
         if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[ID_W-1:0];
         end
      end
   end

   // Next-state and datapath register update for the three-state sequencer.
   always_comb begin
      state_d        = state_q;
      rr_ptr_d       = rr_ptr_q;
      id_d           = id_q;
      alu_opcode_d   = alu_opcode_q;
      alu_a_d        = alu_a_q;
      alu_b_d        = alu_b_q;
      rsp_valid_d    = rsp_valid_q;
      rsp_id_d       = rsp_id_q;
      rsp_out_d      = rsp_out_q;
      rsp_negative_d = rsp_negative_q;
      rsp_overflow_d = rsp_overflow_q;
      rsp_zero_d     = rsp_zero_q;
      ops_done_d     = ops_done_q;
      ready_c        = '0;

      case (state_q)
         ST_IDLE: begin
            if (grant_found) begin
               ready_c      = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
               alu_opcode_d = op_arr[grant_idx];
               alu_a_d      = a_arr[grant_idx];
               alu_b_d      = b_arr[grant_idx];
               id_d         = grant_idx;
               if (grant_idx == ID_W'(NUM_REQ-1)) begin
                  rr_ptr_d = '0;
               end else begin
                  rr_ptr_d = grant_idx + ID_W'(1);
               end
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            rsp_out_d      = alu_out;
            rsp_negative_d = alu_negative;
            rsp_overflow_d = alu_overflow;
            rsp_zero_d     = alu_zero;
            rsp_id_d       = id_q;
            rsp_valid_d    = 1'b1;
            state_d        = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_valid_q && rsp_ready) begin
               rsp_valid_d = 1'b0;
               ops_done_d  = ops_done_q + 16'd1;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // Ready is a combinational strobe; gating with rst_n keeps it low while reset is held.
   assign req_ready = ready_c & {NUM_REQ{rst_n}};

   // State, pointer, ALU-input and response registers; reset drops any in-flight op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         rr_ptr_q       <= '0;
         id_q           <= '0;
         alu_opcode_q   <= '0;
         alu_a_q        <= '0;
         alu_b_q        <= '0;
         rsp_valid_q    <= 1'b0;
         rsp_id_q       <= '0;
         rsp_out_q      <= '0;
         rsp_negative_q <= 1'b0;
         rsp_overflow_q <= 1'b0;
         rsp_zero_q     <= 1'b0;
         ops_done_q     <= '0;
      end else begin
         state_q        <= state_d;
         rr_ptr_q       <= rr_ptr_d;
         id_q           <= id_d;
         alu_opcode_q   <= alu_opcode_d;
         alu_a_q        <= alu_a_d;
         alu_b_q        <= alu_b_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_id_q       <= rsp_id_d;
         rsp_out_q      <= rsp_out_d;
         rsp_negative_q <= rsp_negative_d;
         rsp_overflow_q <= rsp_overflow_d;
         rsp_zero_q     <= rsp_zero_d;
         ops_done_q     <= ops_done_d;
      end
   end

   assign alu_opcode   = alu_opcode_q;
   assign alu_a        = alu_a_q;
   assign alu_b        = alu_b_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_id       = rsp_id_q;
   assign rsp_out      = rsp_out_q;
   assign rsp_negative = rsp_negative_q;
   assign rsp_overflow = rsp_overflow_q;
   assign rsp_zero     = rsp_zero_q;
   assign ops_done     = ops_done_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler
// Directed bench: a small behavioural ALU sits on the alu_* port; every
// expected response value below is worked out by hand.

module tb_alu_rr_scheduler;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 32;
   localparam int OP_W    = 4;
   localparam int ID_W    = 2;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_AND = 4'h2;
   localparam logic [3:0] OP_OR  = 4'h3;

   logic                      clk;
   logic                      rst_n;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*OP_W-1:0]   req_opcode;
   logic [NUM_REQ*DATA_W-1:0] req_a;
   logic [NUM_REQ*DATA_W-1:0] req_b;
   logic [OP_W-1:0]           alu_opcode;
   logic [DATA_W-1:0]         alu_a;
   logic [DATA_W-1:0]         alu_b;
   logic [DATA_W-1:0]         alu_out;
   logic                      alu_negative;
   logic                      alu_overflow;
   logic                      alu_zero;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [ID_W-1:0]           rsp_id;
   logic [DATA_W-1:0]         rsp_out;
   logic                      rsp_negative;
   logic                      rsp_overflow;
   logic                      rsp_zero;
   logic [15:0]               ops_done;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   alu_rr_scheduler #(
      .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .OP_W(OP_W), .ID_W(ID_W)
   ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
      .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
      .alu_out(alu_out), .alu_negative(alu_negative),
      .alu_overflow(alu_overflow), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_out(rsp_out), .rsp_negative(rsp_negative),
      .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
      .ops_done(ops_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural stand-in for the shared ALU
   always_comb begin
      alu_out      = '0;
      alu_overflow = 1'b0;
      case (alu_opcode)
         OP_ADD: begin
            alu_out      = alu_a + alu_b;
            alu_overflow = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
         end
         OP_SUB: begin
            alu_out      = alu_a - alu_b;
            alu_overflow = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
         end
         OP_AND:  alu_out = alu_a & alu_b;
         OP_OR:   alu_out = alu_a | alu_b;
         default: alu_out = '0;
      endcase
      alu_negative = alu_out[31];
      alu_zero     = (alu_out == '0);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b);
      req_opcode[i*OP_W +: OP_W]   = op;
      req_a[i*DATA_W +: DATA_W]    = a;
      req_b[i*DATA_W +: DATA_W]    = b;
   endtask

   // Called at a negedge; waits a bounded number of cycles for rsp_valid.
   task automatic wait_rsp(input int limit);
      int n;
      n = 0;
      while (rsp_valid !== 1'b1 && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (rsp_valid !== 1'b1) check_eq("rsp_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      req_valid = '0;
      rst_n     = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   logic [31:0] rr_exp [4];
   int          last_cyc;
   logic        seen;

   initial begin
      rr_exp[0] = 32'h101;
      rr_exp[1] = 32'h202;
      rr_exp[2] = 32'h303;
      rr_exp[3] = 32'h404;

      rst_n      = 1'b0;
      req_valid  = 4'b1111;
      rsp_ready  = 1'b1;
      req_opcode = '0;
      req_a      = '0;
      req_b      = '0;

      // Reset state with every requester asserting valid
      repeat (3) @(negedge clk);
      check_eq("rst_req_ready", 32'(req_ready), 32'd0);
      check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("rst_ops_done",  32'(ops_done),  32'd0);
      check_eq("rst_alu_a",     alu_a,          32'd0);
      req_valid = '0;
      rst_n     = 1'b1;
      @(negedge clk);

      // Single op: req0 ADD 5+7, accepted in cycle T, response in T+2
      set_req(0, OP_ADD, 32'd5, 32'd7);
      req_valid = 4'b0001;
      #1;
      check_eq("single_ready_T", 32'(req_ready), 32'h1);
      @(negedge clk);
      check_eq("single_ready_exec", 32'(req_ready), 32'h0);
      check_eq("single_rsp_T1",     32'(rsp_valid), 32'h0);
      check_eq("single_alu_a",      alu_a,          32'd5);
      check_eq("single_alu_b",      alu_b,          32'd7);
      req_valid = '0;
      @(negedge clk);
      check_eq("single_rsp_T2",  32'(rsp_valid),    32'h1);
      check_eq("single_id",      32'(rsp_id),       32'h0);
      check_eq("single_out",     rsp_out,           32'd12);
      check_eq("single_zero",    32'(rsp_zero),     32'h0);
      check_eq("single_neg",     32'(rsp_negative), 32'h0);
      @(negedge clk);
      check_eq("single_rsp_done", 32'(rsp_valid), 32'h0);
      check_eq("single_ops_done", 32'(ops_done),  32'd1);
      check_eq("single_alu_hold", alu_a,          32'd5);

      // Round-robin with all four valid and the sink always ready
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) begin
         set_req(i, OP_ADD, 32'h100 * (i + 1), 32'(i + 1));
      end
      req_valid = 4'b1111;
      last_cyc  = 0;
      for (int k = 0; k < 6; k++) begin
         wait_rsp(10);
         check_eq("rr_id",  32'(rsp_id), 32'(k % 4));
         check_eq("rr_out", rsp_out,     rr_exp[k % 4]);
         if (k > 0) check_eq("rr_spacing", 32'(cyc - last_cyc), 32'd3);
         last_cyc = cyc;
         if (k == 5) req_valid = '0;
         @(negedge clk);
      end
      check_eq("rr_ops_done", 32'(ops_done), 32'd6);

      // Backpressure: req2 granted (pointer at 2), req1 waits behind a stalled response
      set_req(2, OP_ADD, 32'd100, 32'd23);
      set_req(1, OP_SUB, 32'd3, 32'd3);
      rsp_ready = 1'b0;
      req_valid = 4'b0110;
      #1;
      check_eq("bp_grant2", 32'(req_ready), 32'b0100);
      @(negedge clk);
      req_valid = 4'b0010;
      @(negedge clk);
      for (int c = 0; c < 10; c++) begin
         check_eq("bp_ctl", 32'({rsp_valid, rsp_id, req_ready}), 32'b1_10_0000);
         check_eq("bp_out", rsp_out, 32'd123);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      check_eq("bp_grant1",    32'(req_ready), 32'b0010);
      check_eq("bp_ops_done",  32'(ops_done),  32'd7);
      @(negedge clk);
      req_valid = '0;
      wait_rsp(5);
      check_eq("sub_id",   32'(rsp_id),       32'd1);
      check_eq("sub_out",  rsp_out,           32'd0);
      check_eq("sub_zero", 32'(rsp_zero),     32'd1);
      check_eq("sub_ovf",  32'(rsp_overflow), 32'd0);
      check_eq("sub_neg",  32'(rsp_negative), 32'd0);
      @(negedge clk);
      check_eq("sub_ops_done", 32'(ops_done), 32'd8);

      // Signed overflow: 0x7FFFFFFF + 1 through requester 3
      set_req(3, OP_ADD, 32'h7FFF_FFFF, 32'd1);
      req_valid = 4'b1000;
      #1;
      check_eq("ovf_grant3", 32'(req_ready), 32'b1000);
      @(negedge clk);
      req_valid = '0;
      wait_rsp(5);
      check_eq("ovf_id",   32'(rsp_id),       32'd3);
      check_eq("ovf_out",  rsp_out,           32'h8000_0000);
      check_eq("ovf_ovf",  32'(rsp_overflow), 32'd1);
      check_eq("ovf_neg",  32'(rsp_negative), 32'd1);
      check_eq("ovf_zero", 32'(rsp_zero),     32'd0);
      @(negedge clk);

      // Reset during EXEC: no response afterwards, pointer back to 0
      set_req(2, OP_AND, 32'hFF, 32'h0F);
      req_valid = 4'b0100;
      @(negedge clk);
      req_valid = '0;
      #2 rst_n = 1'b0;
      #1;
      check_eq("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("mid_rst_ops_done",  32'(ops_done),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         seen = seen | rsp_valid;
      end
      check_eq("mid_rst_no_rsp", 32'(seen), 32'd0);
      req_valid = 4'b1010;
      #1;
      check_eq("mid_rst_grant_low", 32'(req_ready), 32'b0010);
      @(negedge clk);
      req_valid = '0;
      wait_rsp(5);
      check_eq("mid_rst_id", 32'(rsp_id), 32'd1);
      @(negedge clk);
      check_eq("mid_rst_ops_done_1", 32'(ops_done), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
